// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PCIe logical-layer symbols, LFSR helpers and Rx descrambler states
package pcie_phy_pkg;

   localparam logic [7:0]  SYM_COM   = 8'hBC;
   localparam logic [7:0]  SYM_SKP   = 8'h1C;
   localparam logic [7:0]  SYM_IDL   = 8'h7C;
   localparam logic [15:0] LFSR_SEED = 16'hFFFF;
   localparam int          TS_LEN    = 16;

   typedef enum logic [1:0] {
      ST_DATA,
      ST_OS_TYPE,
      ST_TS_BODY
   } scr_state_t;

   // Eight serial steps of X^16+X^5+X^4+X^3+1; returns {mask, next_lfsr}.
   function automatic logic [23:0] lfsr_byte_step(input logic [15:0] lfsr);
      logic [15:0] l;
      logic [7:0]  m;
      l = lfsr;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         m[i] = l[15];
         l    = {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1:0], l[15]};
      end
      return {m, l};
   endfunction

endpackage

// File: rtl/scramble_lfsr.sv
// rtl/scramble_lfsr.sv - scrambler LFSR register with seed/hold/advance and byte mask output
module scramble_lfsr
   import pcie_phy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load_seed,
   input  logic       advance,
   output logic [7:0] mask
);

   logic [15:0] lfsr;
   logic [23:0] step;

   assign step = lfsr_byte_step(lfsr);
   assign mask = step[23:16];

   always_ff @(posedge clk) begin
      if (reset || load_seed) begin
         lfsr <= LFSR_SEED;
      end else if (advance) begin
         lfsr <= step[15:0];
      end
   end

endmodule

// File: rtl/rx_scramble_ctrl.sv
// rtl/rx_scramble_ctrl.sv - Rx descrambler control: LFSR sequencing and TS1/TS2 scramble masking
module rx_scramble_ctrl
   import pcie_phy_pkg::*;
(
   input  logic       ClkPci,
   input  logic       Reset,
   input  logic       InValid,
   input  logic [7:0] InByte,
   input  logic       InCtrl,
   input  logic       DisableScramble,
   output logic [7:0] NextScXor,
   output logic       NextScramble,
   output logic       InOrderedSet
);

   // COM and the OS-type symbol are consumed before the body counter starts.
   localparam logic [3:0] TS_BODY_LEN = 4'(TS_LEN - 2);

   scr_state_t state;
   logic [3:0] count;
   logic       in_os;
   logic       is_com;
   logic       is_skp;
   logic       is_idl;

   assign is_com = InCtrl && (InByte == SYM_COM);
   assign is_skp = InCtrl && (InByte == SYM_SKP);
   assign is_idl = InCtrl && (InByte == SYM_IDL);

   scramble_lfsr u_lfsr (
      .clk       (ClkPci),
      .reset     (Reset),
      .load_seed (InValid && is_com),
      .advance   (InValid && !is_com && !is_skp),
      .mask      (NextScXor)
   );

   assign NextScramble = InValid && !InCtrl && !DisableScramble && (state == ST_DATA);
   assign InOrderedSet = in_os;

   always_ff @(posedge ClkPci) begin
      if (Reset) begin
         state <= ST_DATA;
         count <= '0;
         in_os <= 1'b0;
      end else if (InValid) begin
         if (is_com) begin
            state <= ST_OS_TYPE;
            count <= '0;
            in_os <= 1'b0;
         end else begin
            case (state)
               ST_DATA: state <= ST_DATA;
               ST_OS_TYPE: begin
                  if (is_skp || is_idl) begin
                     state <= ST_DATA;
                  end else begin
                     state <= ST_TS_BODY;
                     count <= TS_BODY_LEN;
                     in_os <= 1'b1;
                  end
               end
               ST_TS_BODY: begin
                  count <= count - 4'd1;
                  if (count == 4'd1) begin
                     state <= ST_DATA;
                     in_os <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_DATA;
                  in_os <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
